// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end sharing one subtractive GCD engine among NREQ requesters.
// One operation in flight; tagged result held in DONE until rsp_ready.
module gcd_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IW   = 2,
  parameter int CW   = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_gcd,
  output logic [IW-1:0]     rsp_id,
  output logic [CW-1:0]     rsp_iters,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a, b;
  logic [IW-1:0] id, rr_ptr, grant;
  logic [CW-1:0] iters;
  logic          found;
  logic          calc_done;
  logic [W-1:0]  calc_result;
  int            idx;

  // first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  assign calc_done   = (a == '0) || (b == '0) || (a == b);
  assign calc_result = (a == '0) ? b : a;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found && !ARESET) begin
          req_ready[grant] = 1'b1;
          state_nxt        = CALC;
        end
      end
      CALC:    if (calc_done) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      a         <= '0;
      b         <= '0;
      id        <= '0;
      iters     <= '0;
      rsp_valid <= 1'b0;
      rsp_gcd   <= '0;
      rsp_id    <= '0;
      rsp_iters <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            a      <= req_a[int'(grant)*W +: W];
            b      <= req_b[int'(grant)*W +: W];
            id     <= grant;
            iters  <= '0;
            rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + 1'b1;
          end
        end
        CALC: begin
          if (calc_done) begin
            rsp_gcd   <= calc_result;
            rsp_id    <= id;
            rsp_iters <= iters;
            rsp_valid <= 1'b1;
          end else begin
            if (a > b) a <= a - b;
            else       b <= b - a;
            // saturate rather than wrap on very long reductions
            if (iters != '1) iters <= iters + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
